// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default bus/field widths and the
// assembler state encoding used by the opcode queue.
package cpu_pkg;

  localparam int DEF_WORD_W  = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_INSTR_W = 8;
  localparam int DEF_SEL_W   = 2;
  localparam int DEF_FLAG_W  = 4;
  localparam int DEF_EXT_BIT = 0;

  typedef enum logic [0:0] {
    ASM_IDLE     = 1'b0,
    ASM_WAIT_IMM = 1'b1
  } asm_state_e;

endpackage

// File: rtl/opcode_fifo_mem.sv
// Entry storage for the opcode queue: register array with one write port and
// an asynchronous read of the head entry. Only the pointers are reset.
module opcode_fifo_mem #(
  parameter int ENTRY_W = 33,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic               clear,
  output logic [ENTRY_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  // DEPTH is a power of two, so plain increment wraps the pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/opcode_queue.sv
// Prefetch queue between bus fetch and control unit; pairs extended opcodes
// with their trailing immediate word before exposing them at the head.
module opcode_queue
  import cpu_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int FLAG_W  = DEF_FLAG_W,
  parameter int EXT_BIT = DEF_EXT_BIT,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int ENTRY_W = 2 * WORD_W + 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               LOAD,
  input  logic [WORD_W-1:0]  DATA_BUS,
  output logic               READY,
  input  logic               FLUSH,
  input  logic               NEXT,
  output logic               VALID,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic [SEL_W-1:0]   DST_SELECTION,
  output logic [SEL_W-1:0]   SRC_SELECTION,
  output logic [FLAG_W-1:0]  FLAG,
  output logic               HAS_IMM,
  output logic [WORD_W-1:0]  IMMEDIATE,
  output logic [CNT_W-1:0]   COUNT
);

  asm_state_e          state_q, state_d;
  logic [WORD_W-1:0]   staging_q, staging_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                ready;
  logic                valid;
  logic                accept;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic [WORD_W-1:0]   head_word;
  logic [WORD_W-1:0]   head_imm;
  logic                head_has_imm;

  assign ready  = (count_q < CNT_W'(DEPTH));
  assign valid  = (count_q != '0);
  assign accept = LOAD && ready && !FLUSH;
  assign pop    = NEXT && valid && !FLUSH;

  // The second word of an extended instruction is always the immediate,
  // whatever its flag bits say.
  always_comb begin
    state_d    = state_q;
    staging_d  = staging_q;
    push       = 1'b0;
    push_entry = {DATA_BUS, {WORD_W{1'b0}}, 1'b0};
    if (FLUSH) begin
      state_d   = ASM_IDLE;
      staging_d = '0;
    end else if (accept) begin
      case (state_q)
        ASM_IDLE: begin
          if (DATA_BUS[EXT_BIT]) begin
            staging_d = DATA_BUS;
            state_d   = ASM_WAIT_IMM;
          end else begin
            push = 1'b1;
          end
        end
        ASM_WAIT_IMM: begin
          push       = 1'b1;
          push_entry = {staging_q, DATA_BUS, 1'b1};
          staging_d  = '0;
          state_d    = ASM_IDLE;
        end
        default: state_d = ASM_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (FLUSH) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ASM_IDLE;
      staging_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      staging_q <= staging_d;
      count_q   <= count_d;
    end
  end

  opcode_fifo_mem #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (pop),
    .clear   (FLUSH),
    .rd_data (head_entry)
  );

  assign head_word    = head_entry[ENTRY_W-1 -: WORD_W];
  assign head_imm     = head_entry[WORD_W:1];
  assign head_has_imm = head_entry[0];

  // Head storage may be stale or uninitialised while empty, so every field is gated.
  always_comb begin
    INSTRUCTION   = '0;
    DST_SELECTION = '0;
    SRC_SELECTION = '0;
    FLAG          = '0;
    HAS_IMM       = 1'b0;
    IMMEDIATE     = '0;
    if (valid) begin
      INSTRUCTION   = head_word[WORD_W-1 -: INSTR_W];
      DST_SELECTION = head_word[FLAG_W+2*SEL_W-1 -: SEL_W];
      SRC_SELECTION = head_word[FLAG_W+SEL_W-1 -: SEL_W];
      FLAG          = head_word[FLAG_W-1:0];
      HAS_IMM       = head_has_imm;
      IMMEDIATE     = head_has_imm ? head_imm : '0;
    end
  end

  assign READY = ready;
  assign VALID = valid;
  assign COUNT = count_q;

endmodule

// File: tb/tb_opcode_queue.sv
// Directed self-checking bench for opcode_queue with hand-computed expectations.
module tb_opcode_queue;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        LOAD;
  logic [15:0] DATA_BUS;
  logic        READY;
  logic        FLUSH;
  logic        NEXT;
  logic        VALID;
  logic [7:0]  INSTRUCTION;
  logic [1:0]  DST_SELECTION;
  logic [1:0]  SRC_SELECTION;
  logic [3:0]  FLAG;
  logic        HAS_IMM;
  logic [15:0] IMMEDIATE;
  logic [2:0]  COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  opcode_queue dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .LOAD          (LOAD),
    .DATA_BUS      (DATA_BUS),
    .READY         (READY),
    .FLUSH         (FLUSH),
    .NEXT          (NEXT),
    .VALID         (VALID),
    .INSTRUCTION   (INSTRUCTION),
    .DST_SELECTION (DST_SELECTION),
    .SRC_SELECTION (SRC_SELECTION),
    .FLAG          (FLAG),
    .HAS_IMM       (HAS_IMM),
    .IMMEDIATE     (IMMEDIATE),
    .COUNT         (COUNT)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic load, input logic [15:0] word, input logic next, input logic flush);
    LOAD     = load;
    DATA_BUS = word;
    NEXT     = next;
    FLUSH    = flush;
    @(posedge CLK);
    #1;
    LOAD     = 1'b0;
    DATA_BUS = 16'h0000;
    NEXT     = 1'b0;
    FLUSH    = 1'b0;
  endtask

  task automatic checkHeadEmpty(input string tag);
    checkOutput({tag, "_valid"}, 32'(VALID), 32'd0);
    checkOutput({tag, "_count"}, 32'(COUNT), 32'd0);
    checkOutput({tag, "_instr"}, 32'(INSTRUCTION), 32'd0);
    checkOutput({tag, "_imm"},   32'(IMMEDIATE), 32'd0);
  endtask

  initial begin
    RST_N    = 1'b0;
    LOAD     = 1'b0;
    DATA_BUS = 16'h0000;
    NEXT     = 1'b0;
    FLUSH    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkHeadEmpty("in_reset");
    checkOutput("in_reset_ready", 32'(READY), 32'd1);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checkHeadEmpty("after_reset");
    checkOutput("after_reset_ready", 32'(READY), 32'd1);
    checkOutput("after_reset_flag", 32'(FLAG), 32'd0);
    checkOutput("after_reset_dst", 32'(DST_SELECTION), 32'd0);

    // Plain decode of A5_9C.
    applyStimulus(1'b1, 16'hA59C, 1'b0, 1'b0);
    checkOutput("plain_valid", 32'(VALID), 32'd1);
    checkOutput("plain_instr", 32'(INSTRUCTION), 32'hA5);
    checkOutput("plain_dst", 32'(DST_SELECTION), 32'h2);
    checkOutput("plain_src", 32'(SRC_SELECTION), 32'h1);
    checkOutput("plain_flag", 32'(FLAG), 32'hC);
    checkOutput("plain_has_imm", 32'(HAS_IMM), 32'd0);
    checkOutput("plain_imm", 32'(IMMEDIATE), 32'd0);
    checkOutput("plain_count", 32'(COUNT), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkHeadEmpty("plain_pop");

    // Extended instruction 12_31 followed by immediate BEEF.
    applyStimulus(1'b1, 16'h1231, 1'b0, 1'b0);
    checkOutput("ext_first_valid", 32'(VALID), 32'd0);
    checkOutput("ext_first_count", 32'(COUNT), 32'd0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
    checkOutput("ext_valid", 32'(VALID), 32'd1);
    checkOutput("ext_instr", 32'(INSTRUCTION), 32'h12);
    checkOutput("ext_dst", 32'(DST_SELECTION), 32'h0);
    checkOutput("ext_src", 32'(SRC_SELECTION), 32'h3);
    checkOutput("ext_flag", 32'(FLAG), 32'h1);
    checkOutput("ext_has_imm", 32'(HAS_IMM), 32'd1);
    checkOutput("ext_imm", 32'(IMMEDIATE), 32'hBEEF);
    checkOutput("ext_count", 32'(COUNT), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkHeadEmpty("ext_pop");

    // Fill past full three times so the pointers wrap.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 1; i <= 5; i++) begin
        applyStimulus(1'b1, 16'(i << 8), 1'b0, 1'b0);
      end
      checkOutput($sformatf("full%0d_count", rep), 32'(COUNT), 32'd4);
      checkOutput($sformatf("full%0d_ready", rep), 32'(READY), 32'd0);
      for (int i = 1; i <= 4; i++) begin
        checkOutput($sformatf("full%0d_head%0d", rep, i), 32'(INSTRUCTION), 32'(i));
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      end
      checkOutput($sformatf("full%0d_drained", rep), 32'(VALID), 32'd0);
    end

    // Concurrent push and pop.
    applyStimulus(1'b1, 16'h0600, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0700, 1'b0, 1'b0);
    checkOutput("cc_pre_count", 32'(COUNT), 32'd2);
    applyStimulus(1'b1, 16'h0800, 1'b1, 1'b0);
    checkOutput("cc_count", 32'(COUNT), 32'd2);
    checkOutput("cc_head", 32'(INSTRUCTION), 32'h07);
    applyStimulus(1'b1, 16'h0900, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0A00, 1'b0, 1'b0);
    checkOutput("cc_full_count", 32'(COUNT), 32'd4);
    applyStimulus(1'b1, 16'h0B00, 1'b1, 1'b0);
    checkOutput("cc_full_pop_count", 32'(COUNT), 32'd3);
    checkOutput("cc_full_pop_ready", 32'(READY), 32'd1);
    checkOutput("cc_full_pop_head", 32'(INSTRUCTION), 32'h08);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("cc_drain_09", 32'(INSTRUCTION), 32'h09);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("cc_drain_0a", 32'(INSTRUCTION), 32'h0A);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("cc_drained", 32'(VALID), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("next_on_empty_count", 32'(COUNT), 32'd0);

    // Flush while an extended opcode awaits its immediate.
    applyStimulus(1'b1, 16'h0C00, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0D00, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0E00, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2001, 1'b0, 1'b0);
    checkOutput("fl_wait_count", 32'(COUNT), 32'd3);
    applyStimulus(1'b1, 16'h3000, 1'b1, 1'b1);
    checkHeadEmpty("fl_after");
    applyStimulus(1'b1, 16'h4000, 1'b0, 1'b0);
    checkOutput("fl_fresh_instr", 32'(INSTRUCTION), 32'h40);
    checkOutput("fl_fresh_has_imm", 32'(HAS_IMM), 32'd0);
    checkOutput("fl_fresh_count", 32'(COUNT), 32'd1);

    // Asynchronous reset mid-assembly, between clock edges.
    applyStimulus(1'b1, 16'h5001, 1'b0, 1'b0);
    checkOutput("ar_pre_count", 32'(COUNT), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    checkHeadEmpty("ar_async");
    checkOutput("ar_async_ready", 32'(READY), 32'd1);
    #1;
    RST_N = 1'b1;
    applyStimulus(1'b1, 16'h6000, 1'b0, 1'b0);
    checkOutput("ar_fresh_instr", 32'(INSTRUCTION), 32'h60);
    checkOutput("ar_fresh_has_imm", 32'(HAS_IMM), 32'd0);
    checkOutput("ar_fresh_count", 32'(COUNT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/opcode_queue.md
Name: opcode_queue

Overview:
Parametrised successor to the single-word opcode latch. It buffers up to DEPTH decoded instructions between the bus-fetch sequencer and the control unit. Extended instructions carry a trailing immediate word; the block assembles the opcode and immediate into one queue entry before the control unit sees it. Fetch can therefore run ahead of execution, and a taken jump discards the prefetched instructions with FLUSH.

Parameters:
WORD_W, 16, bus word width; must equal INSTR_W + 2*SEL_W + FLAG_W
DEPTH, 4, queue entries; power of two, >= 2
INSTR_W, 8, opcode field width (field occupies the top bits of the word)
SEL_W, 2, width of each of the DST and SRC select fields
FLAG_W, 4, flag field width (field occupies the bottom bits of the word)
EXT_BIT, 0, index within FLAG of the bit marking "immediate word follows"

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous, active-low reset
LOAD  in  1  DATA_BUS carries an instruction or immediate word this cycle
DATA_BUS  in  WORD_W  fetched word
READY  out  1  queue can accept LOAD this cycle
FLUSH  in  1  discard all entries and any half-assembled instruction
NEXT  in  1  control unit consumes the head entry
VALID  out  1  head entry present
INSTRUCTION  out  INSTR_W  head opcode field
DST_SELECTION  out  SEL_W  head destination select
SRC_SELECTION  out  SEL_W  head source select
FLAG  out  FLAG_W  head flag field
HAS_IMM  out  1  head entry carries an immediate
IMMEDIATE  out  WORD_W  head immediate word; 0 when HAS_IMM=0
COUNT  out  clog2(DEPTH+1)  number of complete entries held

Behaviour:
- Reset (RST_N low, asynchronous): queue empty, read/write pointers 0, assembler in IDLE, staging register 0.
  - Reset outputs: VALID=0, COUNT=0, READY=1, all field outputs 0.
- Entry format: {opcode word, immediate word, has_imm}. Field slicing follows the legacy layout: INSTRUCTION at the top, then DST, then SRC, then FLAG at the bottom.
- READY = (COUNT < DEPTH). A LOAD with READY=0 is ignored: no state change, and the word is lost. The sequencer must not do this.
- Assembler FSM, evaluated on each accepted LOAD (LOAD && READY):
  - IDLE, word FLAG[EXT_BIT]=0: push {word, 0, 0}; stay IDLE.
  - IDLE, word FLAG[EXT_BIT]=1: latch word into staging; go to WAIT_IMM; nothing pushed.
  - WAIT_IMM: push {staging, word, 1}; go to IDLE. The second word is taken as an immediate regardless of its bits.
- Push/visibility: a pushed entry is visible at the outputs from the clock edge on which it is written. This is one-cycle LOAD-to-VALID latency, the same as the legacy latch.
- Head outputs: driven combinationally from the stored head entry and forced to 0 when VALID=0. No bus value ever reaches the outputs combinationally.
- Pop: NEXT && VALID advances the read pointer. NEXT while VALID=0 is ignored.
- Simultaneous push and pop: allowed whenever READY=1. COUNT is unchanged and both pointers advance.
  - Full and NEXT in the same cycle: READY is 0 that cycle, so no push occurs. READY rises the following cycle.
- Pointers wrap modulo DEPTH. COUNT is tracked explicitly; full/empty are never derived from pointer equality alone.
- FLUSH: synchronous, highest priority over LOAD and NEXT in the same cycle.
  - Next cycle: COUNT=0, VALID=0, assembler in IDLE, staging discarded.
- FLUSH while in WAIT_IMM: the pending opcode is dropped, and the next LOAD is decoded as a fresh opcode.
- Asynchronous reset mid-assembly or with a full queue: everything is cleared immediately, without waiting for a clock edge.

Decomposition:
- Shared package (cpu_pkg): WORD_W and the field-width defaults, EXT_BIT, and an assembler-state enum {ASM_IDLE, ASM_WAIT_IMM}.
- Sub-module opcode_fifo_mem: a DEPTH x (2*WORD_W+1) register array with write port, read pointer and asynchronous read. It holds no reset on data, only on pointers.
- Assembler FSM, COUNT and the field slicing stay in opcode_queue.

Test Plan:
- Reset state: RST_N low, then release → VALID=0, COUNT=0, READY=1, all field outputs 0.
  - Reassert RST_N between clock edges → outputs clear immediately.
- Plain decode: LOAD 16'hA5_9C → next cycle VALID=1, INSTRUCTION=8'hA5, DST=2'b10, SRC=2'b01, FLAG=4'hC, HAS_IMM=0, IMMEDIATE=0. NEXT → VALID=0.
- Extended assembly:
  - LOAD 16'h12_31 → VALID stays 0 (FLAG[0]=1).
  - LOAD 16'hBEEF → VALID=1, INSTRUCTION=8'h12, HAS_IMM=1, IMMEDIATE=16'hBEEF, COUNT=1.
- Full and wrap:
  - LOAD 5 plain words 16'h0100..16'h0500 back-to-back, no NEXT → COUNT=4, READY=0, 5th word dropped.
  - Pop all 4 → INSTRUCTION sequence 01,02,03,04.
  - Repeat twice → pointers wrap and order is preserved.
- Concurrent push/pop at COUNT=2: LOAD and NEXT in the same cycle → COUNT stays 2, head advances.
  - At COUNT=4 with LOAD and NEXT together → COUNT=3, word ignored.
- Flush:
  - Enter WAIT_IMM with LOAD 16'h20_01 while COUNT=3.
  - Assert FLUSH together with LOAD 16'h30_00 → next cycle COUNT=0, VALID=0.
  - Then LOAD 16'h40_00 → INSTRUCTION=8'h40, HAS_IMM=0.
